cam_frame_sequencer: RTL

Frame scheduler for the 2-pixel-per-word camera source model. It sequences reads from a frame ROM that holds two WIDTH-bit pixels per word, and generates the blanking, line-valid and vsync timing. Software-style start/stop control runs a programmed number of frames. Its outputs feed the downstream RGGB/ISP bench in place of a free-running source.

---
 rtl/cam_frame_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cam_frame_sequencer.sv
// rtl/cam_frame_sequencer.sv - frame ROM sequencer with blanking, line-valid and vsync timing
// Optional CAM_SEQ_PATTERN_EN replaces ROM pixels with a (column + line) test pattern.
module cam_frame_sequencer #(
   parameter int WIDTH       = 12,
   parameter int TRUELINE    = 1080,
   parameter int TRUEPIXEL   = 1920,
   parameter int NUM_OF_PIX  = 2020,
   parameter int NUM_OF_LINE = 1100,
   parameter int VS_START    = 8,
   parameter int VS_END      = 13,
   parameter int ROM_AW      = 20,
   parameter int ROM_LAT     = 1
) (
   input  logic                 iclk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [7:0]           frames,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 rom_en,
   output logic [ROM_AW-1:0]    rom_addr,
   input  logic [2*WIDTH-1:0]   rom_data,
   output logic                 sync_out,
   output logic                 line_valid_out,
   output logic [WIDTH-1:0]     data_out
);

   localparam logic [11:0] PIX_LAST  = 12'(NUM_OF_PIX - 1);
   localparam logic [11:0] LINE_LAST = 12'(NUM_OF_LINE - 1);
   localparam logic [11:0] LINE_ACT0 = 12'(NUM_OF_LINE - TRUELINE);
   localparam logic [11:0] PIX_ACT   = 12'(TRUEPIXEL);
   localparam logic [11:0] VS_S      = 12'(VS_START);
   localparam logic [11:0] VS_E      = 12'(VS_END);
   // Control stages between the counters and the output register; ROM data meets stage PL-1.
   localparam int          PL        = ROM_LAT + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   typedef struct packed {
      logic lv;
      logic vs;
      logic even;
      logic fe;
`ifdef CAM_SEQ_PATTERN_EN
      logic [WIDTH-1:0] pat;
`endif
   } ctl_t;

   state_t      state, state_n;
   logic [11:0] pix_cnt, line_cnt, line_idx;
   logic [7:0]  frames_q, done_cnt;
   logic        stop_q;
   logic        line_act, pix_act, vs_raw, frame_end, last_frame;
   ctl_t        ctl_in;
   ctl_t        ctl_pipe [PL];
   ctl_t        ctl_out;

   assign busy    = (state != S_IDLE);
   assign ctl_out = ctl_pipe[PL-1];

   // A stop arriving on the frame-end cycle still counts for the ending frame.
   assign last_frame = stop_q || stop ||
                       ((frames_q != 8'd0) && ((done_cnt + 8'd1) == frames_q));

   always_ff @(posedge iclk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = S_RUN;
         S_RUN:   if (frame_end && last_frame) state_n = S_DRAIN;
         S_DRAIN: if (frame_done) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         pix_cnt  <= '0;
         line_cnt <= '0;
         frames_q <= '0;
         done_cnt <= '0;
         stop_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               pix_cnt  <= '0;
               line_cnt <= '0;
               if (start) begin
                  frames_q <= frames;
                  done_cnt <= '0;
                  stop_q   <= stop;
               end else begin
                  stop_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (stop) stop_q <= 1'b1;
               if (pix_cnt == PIX_LAST) begin
                  pix_cnt  <= '0;
                  line_cnt <= (line_cnt == LINE_LAST) ? 12'd0 : line_cnt + 12'd1;
               end else begin
                  pix_cnt  <= pix_cnt + 12'd1;
               end
               if (frame_end) done_cnt <= done_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      line_act  = 1'b0;
      pix_act   = 1'b0;
      vs_raw    = 1'b0;
      frame_end = 1'b0;
      line_idx  = line_cnt - LINE_ACT0;
      if (state == S_RUN) begin
         line_act  = (line_cnt >= LINE_ACT0);
         pix_act   = line_act && (pix_cnt < PIX_ACT);
         vs_raw    = (line_cnt >= VS_S) && (line_cnt <= VS_E);
         frame_end = (pix_cnt == PIX_LAST) && (line_cnt == LINE_LAST);
      end
   end

   always_comb begin
      ctl_in      = '0;
      ctl_in.lv   = pix_act;
      ctl_in.vs   = vs_raw;
      ctl_in.even = ~pix_cnt[0];
      ctl_in.fe   = frame_end;
`ifdef CAM_SEQ_PATTERN_EN
      ctl_in.pat  = WIDTH'(pix_cnt) + WIDTH'(line_idx);
`endif
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         for (int k = 0; k < PL; k++) ctl_pipe[k] <= '0;
      end else begin
         ctl_pipe[0] <= ctl_in;
         for (int k = 1; k < PL; k++) ctl_pipe[k] <= ctl_pipe[k-1];
      end
   end

`ifdef CAM_SEQ_PATTERN_EN
   logic unused_rom_data;
   assign unused_rom_data = ^rom_data;
   assign rom_en          = 1'b0;
   assign rom_addr        = '0;

   always_ff @(posedge iclk) begin
      if (rst) begin
         sync_out       <= 1'b0;
         line_valid_out <= 1'b0;
         frame_done     <= 1'b0;
         data_out       <= '0;
      end else begin
         sync_out       <= ctl_out.vs;
         line_valid_out <= ctl_out.lv;
         frame_done     <= ctl_out.fe;
         data_out       <= ctl_out.lv ? ctl_out.pat : '0;
      end
   end
`else
   logic [ROM_AW-1:0] rd_addr;
   logic [WIDTH-1:0]  odd_hold;

   assign rd_addr = ROM_AW'(line_idx) * ROM_AW'(TRUEPIXEL / 2) + ROM_AW'(pix_cnt[11:1]);

   always_ff @(posedge iclk) begin
      if (rst) begin
         rom_en   <= 1'b0;
         rom_addr <= '0;
      end else begin
         rom_en <= pix_act && ~pix_cnt[0];
         if (pix_act && ~pix_cnt[0]) rom_addr <= rd_addr;
      end
   end

   // The word arrives with the even pixel; its odd half is parked for the following cycle.
   always_ff @(posedge iclk) begin
      if (rst) begin
         sync_out       <= 1'b0;
         line_valid_out <= 1'b0;
         frame_done     <= 1'b0;
         data_out       <= '0;
         odd_hold       <= '0;
      end else begin
         sync_out       <= ctl_out.vs;
         line_valid_out <= ctl_out.lv;
         frame_done     <= ctl_out.fe;
         if (ctl_out.lv && ctl_out.even) odd_hold <= rom_data[WIDTH-1:0];
         if (!ctl_out.lv)       data_out <= '0;
         else if (ctl_out.even) data_out <= rom_data[2*WIDTH-1:WIDTH];
         else                   data_out <= odd_hold;
      end
   end
`endif

endmodule
